rv0_ifu_pc: RTL

- Fetch-side PC generator and redirect consumer. It sits at the receiving end of the branch execute unit's resolution path.
- Accepts branch/jump resolutions from the EXU branch unit and steers instruction fetch.
- Issues fetch requests to instruction memory, buffers the returned words and feeds them to the IDU with their PC tag.
- Squashes stale fetches after a redirect.

---
 rtl/rv0_ifu_pc.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rv0_ifu_pc.sv
`default_nettype none
// ============================================================================
// Module : rv0_ifu_pc
// Fetch PC generator and branch-redirect consumer; feeds tagged words to IDU.
// Optional feature macro: RV0_IFU_PERF_CNT_EN (adds perf_redirect_cnt_o).
// Rev    : 1.0  initial release
// ============================================================================
module rv0_ifu_pc #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR    = '0,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            br_valid_i,
  output logic            br_ready_o,
  input  logic            br_redirect_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic            exu_flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            idu_valid_o,
  input  logic            idu_ready_i,
  output logic [XLEN-1:0] idu_instr_o,
  output logic [XLEN-1:0] idu_pc_o
`ifdef RV0_IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_redirect_cnt_o
`endif
);

  localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_CNT_W-1:0] c_MAX      = c_CNT_W'(MAX_OUTSTANDING);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XLEN-1:0]     r_pc;
  logic [c_CNT_W-1:0]  r_inflight;
  logic [c_CNT_W-1:0]  r_fifo_cnt;
  logic [c_CNT_W-1:0]  r_discard;
  logic [c_CNT_W-1:0]  w_discard_nxt;
  logic [c_CNT_W-1:0]  w_inflight_nxt;
  logic [c_CNT_W-1:0]  w_credits;
  logic [c_PTR_W-1:0]  r_tag_wr;
  logic [c_PTR_W-1:0]  r_tag_rd;
  logic [c_PTR_W-1:0]  r_fifo_wr;
  logic [c_PTR_W-1:0]  r_fifo_rd;
  logic                r_flush;
  logic                r_misalign;
  logic [XLEN-1:0]     r_misalign_addr;

  logic [XLEN-1:0]     r_tag_mem  [MAX_OUTSTANDING];
  logic [XLEN-1:0]     r_data_mem [MAX_OUTSTANDING];
  logic [XLEN-1:0]     r_dpc_mem  [MAX_OUTSTANDING];

  logic w_req_valid, w_req_fire, w_br_ready, w_redirect;
  logic w_drop, w_push, w_pop, w_idu_valid;

  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Handshake-facing valids are held low while reset is asserted.
  assign w_credits   = r_inflight + r_fifo_cnt;
  assign w_req_valid = !rst_i && (r_state == ST_RUN) && (w_credits < c_MAX);
  assign w_req_fire  = w_req_valid && imem_req_ready_i;
  assign w_br_ready  = !rst_i && (r_state == ST_RUN);
  assign w_redirect  = br_valid_i && w_br_ready && br_redirect_i;
  assign w_drop      = imem_rsp_valid_i && (r_discard != '0);
  assign w_push      = imem_rsp_valid_i && (r_discard == '0) && !w_redirect;
  assign w_idu_valid = (r_fifo_cnt != '0);
  assign w_pop       = w_idu_valid && idu_ready_i && !w_redirect;

  // Every response retires one tag, whether it is kept or dropped.
  assign w_inflight_nxt = r_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rsp_valid_i);

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    case (r_state)
      ST_RUN: begin
        if (w_redirect) begin
          w_discard_nxt = w_inflight_nxt;
          if (w_inflight_nxt != '0) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_drop) begin
          w_discard_nxt = r_discard - 1'b1;
          if (r_discard == c_CNT_W'(1)) w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= ST_RUN;
      r_pc            <= RESET_VECTOR;
      r_inflight      <= '0;
      r_fifo_cnt      <= '0;
      r_discard       <= '0;
      r_tag_wr        <= '0;
      r_tag_rd        <= '0;
      r_fifo_wr       <= '0;
      r_fifo_rd       <= '0;
      r_flush         <= 1'b0;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_discard  <= w_discard_nxt;
      r_inflight <= w_inflight_nxt;
      if (w_redirect)      r_pc <= {br_target_i[XLEN-1:2], 2'b00};
      else if (w_req_fire) r_pc <= r_pc + XLEN'(4);
      if (w_req_fire)       r_tag_wr <= ptr_inc(r_tag_wr);
      if (imem_rsp_valid_i) r_tag_rd <= ptr_inc(r_tag_rd);
      if (w_redirect) begin
        r_fifo_cnt <= '0;
        r_fifo_wr  <= '0;
        r_fifo_rd  <= '0;
      end else begin
        if (w_push) r_fifo_wr <= ptr_inc(r_fifo_wr);
        if (w_pop)  r_fifo_rd <= ptr_inc(r_fifo_rd);
        r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
      r_flush    <= w_redirect;
      r_misalign <= w_redirect && br_target_i[1];
      if (w_redirect && br_target_i[1]) r_misalign_addr <= br_target_i;
    end
  end

  // Storage arrays carry no reset; occupancy counters qualify their contents.
  always_ff @(posedge clk_i) begin
    if (w_req_fire) r_tag_mem[r_tag_wr] <= r_pc;
    if (w_push) begin
      r_data_mem[r_fifo_wr] <= imem_rsp_data_i;
      r_dpc_mem[r_fifo_wr]  <= r_tag_mem[r_tag_rd];
    end
  end

  assign br_ready_o       = w_br_ready;
  assign exu_flush_o      = r_flush;
  assign misalign_o       = r_misalign;
  assign misalign_addr_o  = r_misalign_addr;
  assign imem_req_valid_o = w_req_valid;
  assign imem_req_addr_o  = r_pc;
  assign idu_valid_o      = w_idu_valid;
  assign idu_instr_o      = w_idu_valid ? r_data_mem[r_fifo_rd] : '0;
  assign idu_pc_o         = w_idu_valid ? r_dpc_mem[r_fifo_rd]  : '0;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && (r_fifo_cnt == c_MAX)));
  a_no_rsp_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rsp_valid_i && (r_inflight == '0)));

`ifdef RV0_IFU_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                 r_perf_cnt <= '0;
    else if (w_redirect && (r_perf_cnt != '1)) r_perf_cnt <= r_perf_cnt + 32'd1;
  end

  assign perf_redirect_cnt_o = r_perf_cnt;
`else
  // Redirect counter not built.
`endif

endmodule
`default_nettype wire
